// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between fetch_stage (master) and instruction memory (slave).
// Request-level handshake: imem_req marks a fetch of imem_addr this cycle; imem_ready=1 means
// imem_rdata holds the word for the current imem_addr in the same cycle. Nothing is outstanding.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register and a one-entry hold buffer for stalled returns.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 pc_sel,
  input  logic [31:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [31:0]          if_id_inst,
  output logic [31:0]          if_id_pc,
  output logic [31:0]          if_id_pc4,
  output logic                 if_id_valid,
  output logic [31:0]          perf_fetch_cnt,
  output logic [31:0]          perf_bubble_cnt,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inst_n, ifpc_n, ifpc4_n;
  logic        valid_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic [31:0] hold_pc, hold_pc_n;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // control_unit drives pc_sel low for a taken jump/branch
  assign redirect = ~pc_sel;
  assign target   = {redirect_pc[31:2], 2'b00};
  assign pc_plus4 = pc + 32'd4;

  assign imem.imem_req  = (state == S_FETCH) && !rst;
  assign imem.imem_addr = pc;
  assign state_dbg      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      if_id_inst  <= NOP_INST;
      if_id_pc    <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      hold_inst   <= 32'd0;
      hold_pc     <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_id_inst  <= inst_n;
      if_id_pc    <= ifpc_n;
      if_id_pc4   <= ifpc4_n;
      if_id_valid <= valid_n;
      hold_inst   <= hold_inst_n;
      hold_pc     <= hold_pc_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    inst_n      = if_id_inst;
    ifpc_n      = if_id_pc;
    ifpc4_n     = if_id_pc4;
    valid_n     = if_id_valid;
    hold_inst_n = hold_inst;
    hold_pc_n   = hold_pc;
    case (state)
      S_BOOT: begin
        state_n = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) begin
          // squash: whatever memory returns this cycle belongs to the wrong path
          pc_n    = target;
          inst_n  = NOP_INST;
          valid_n = 1'b0;
        end else if (stall) begin
          if (imem.imem_ready) begin
            hold_inst_n = imem.imem_rdata;
            hold_pc_n   = pc;
            state_n     = S_HOLD;
          end
        end else if (imem.imem_ready) begin
          inst_n  = imem.imem_rdata;
          ifpc_n  = pc;
          ifpc4_n = pc_plus4;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
        end else begin
          inst_n  = NOP_INST;
          valid_n = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_n    = target;
          inst_n  = NOP_INST;
          valid_n = 1'b0;
          state_n = S_FETCH;
        end else if (!stall) begin
          inst_n  = hold_inst;
          ifpc_n  = hold_pc;
          ifpc4_n = hold_pc + 32'd4;
          valid_n = 1'b1;
          pc_n    = pc_plus4;
          state_n = S_FETCH;
        end
      end
      default: begin
        state_n = S_BOOT;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  logic fetch_evt;
  logic bubble_evt;

  // edges that load IF/ID; stall-hold edges match neither
  assign fetch_evt  = pc_sel && !stall &&
                      (((state == S_FETCH) && imem.imem_ready) || (state == S_HOLD));
  assign bubble_evt = (redirect && (state != S_BOOT)) ||
                      ((state == S_FETCH) && pc_sel && !stall && !imem.imem_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt  <= 32'd0;
      perf_bubble_cnt <= 32'd0;
    end else begin
      if (fetch_evt)  perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (bubble_evt) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`else
  assign perf_fetch_cnt  = 32'd0;
  assign perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot latency, redirect, stall/hold, bubbles, PC wrap and reset.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, rst2;
  logic        stall, pc_sel;
  logic [31:0] redirect_pc;
  logic        ready;

  logic [31:0] inst, ipc, ipc4, inst2, ipc2, ipc42;
  logic        valid, valid2;
  logic [31:0] pf, pb, pf2, pb2;
  logic [1:0]  st, st2;

  int checks = 0;
  int errors = 0;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  assign bus.imem_rdata  = mem(bus.imem_addr);
  assign bus.imem_ready  = ready;
  assign bus2.imem_rdata = mem(bus2.imem_addr);
  assign bus2.imem_ready = 1'b1;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .redirect_pc(redirect_pc),
    .imem(bus.master), .if_id_inst(inst), .if_id_pc(ipc), .if_id_pc4(ipc4),
    .if_id_valid(valid), .perf_fetch_cnt(pf), .perf_bubble_cnt(pb), .state_dbg(st)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst2), .stall(1'b0), .pc_sel(1'b1), .redirect_pc(32'd0),
    .imem(bus2.master), .if_id_inst(inst2), .if_id_pc(ipc2), .if_id_pc4(ipc42),
    .if_id_valid(valid2), .perf_fetch_cnt(pf2), .perf_bubble_cnt(pb2), .state_dbg(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected perf value when counters are built, zero otherwise
  function automatic logic [31:0] pexp(input logic [31:0] v);
`ifdef FETCH_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic chk_out(input string tag, input logic [31:0] e_inst, input logic [31:0] e_pc,
                         input logic e_valid, input logic [31:0] e_addr);
    check({tag, "_inst"}, inst, e_inst);
    check({tag, "_pc"}, ipc, e_pc);
    check({tag, "_pc4"}, ipc4, e_pc + 32'd4);
    check({tag, "_valid"}, {31'd0, valid}, {31'd0, e_valid});
    check({tag, "_addr"}, bus.imem_addr, e_addr);
  endtask

  task automatic chk_bubble(input string tag, input logic [31:0] e_addr);
    check({tag, "_inst"}, inst, NOP);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_addr"}, bus.imem_addr, e_addr);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; stall = 1'b0; pc_sel = 1'b1; redirect_pc = 32'd0; ready = 1'b1;
    tick(); tick();
    check("rst_inst", inst, NOP);
    check("rst_pc", ipc, 32'd0);
    check("rst_pc4", ipc4, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);
    check("rst_perf_f", pf, 32'd0);
    check("rst_perf_b", pb, 32'd0);
    rst = 1'b0;
    #1;
    check("boot_req", {31'd0, bus.imem_req}, 32'd0);
    check("boot_state", {30'd0, st}, 32'd0);

    // 1: sequential fetch, one instruction per cycle
    tick();
    check("e1_req", {31'd0, bus.imem_req}, 32'd1);
    check("e1_valid", {31'd0, valid}, 32'd0);
    check("e1_addr", bus.imem_addr, 32'd0);
    tick(); chk_out("seq0", mem(32'h0), 32'h0, 1'b1, 32'h4);
    tick(); chk_out("seq4", mem(32'h4), 32'h4, 1'b1, 32'h8);
    tick(); chk_out("seq8", mem(32'h8), 32'h8, 1'b1, 32'hC);
    tick(); chk_out("seqC", mem(32'hC), 32'hC, 1'b1, 32'h10);

    // 2: redirect with misaligned target
    pc_sel = 1'b0; redirect_pc = 32'h0000_0103;
    tick(); chk_bubble("redir", 32'h100);
    pc_sel = 1'b1;
    tick(); chk_out("redir_tgt", mem(32'h100), 32'h100, 1'b1, 32'h104);

    // 3: stall with ready at pc=0x20
    pc_sel = 1'b0; redirect_pc = 32'h0000_001C;
    tick(); chk_bubble("to1c", 32'h1C);
    pc_sel = 1'b1;
    tick(); chk_out("f1c", mem(32'h1C), 32'h1C, 1'b1, 32'h20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stall", mem(32'h1C), 32'h1C, 1'b1, 32'h20);
      check("stall_req", {31'd0, bus.imem_req}, 32'd0);
      check("stall_state", {30'd0, st}, 32'd2);
    end
    stall = 1'b0;
    tick(); chk_out("unhold", mem(32'h20), 32'h20, 1'b1, 32'h24);
    check("unhold_req", {31'd0, bus.imem_req}, 32'd1);
    tick(); chk_out("f24", mem(32'h24), 32'h24, 1'b1, 32'h28);

    // 4: redirect while holding
    stall = 1'b1;
    tick(); chk_out("hold28", mem(32'h24), 32'h24, 1'b1, 32'h28);
    pc_sel = 1'b0; redirect_pc = 32'h0000_0200;
    tick(); chk_bubble("hold_redir", 32'h200);
    check("hold_redir_req", {31'd0, bus.imem_req}, 32'd1);
    pc_sel = 1'b1; stall = 1'b0;
    tick(); chk_out("f200", mem(32'h200), 32'h200, 1'b1, 32'h204);

    // 5: memory not ready at 0x40
    pc_sel = 1'b0; redirect_pc = 32'h0000_0040;
    tick(); chk_bubble("to40", 32'h40);
    pc_sel = 1'b1;
    check("perf_f_pre", pf, pexp(32'd9));
    check("perf_b_pre", pb, pexp(32'd4));
    ready = 1'b0;
    tick(); chk_bubble("nr1", 32'h40);
    tick(); chk_bubble("nr2", 32'h40);
    check("perf_f_nr", pf, pexp(32'd9));
    check("perf_b_nr", pb, pexp(32'd6));
    ready = 1'b1;
    tick(); chk_out("f40", mem(32'h40), 32'h40, 1'b1, 32'h44);
    check("perf_f_post", pf, pexp(32'd10));

    // 6: PC wrap and reset mid-stream on the second instance
    rst2 = 1'b0;
    tick();
    check("w_addr0", bus2.imem_addr, 32'hFFFF_FFF8);
    tick();
    check("w_inst0", inst2, mem(32'hFFFF_FFF8));
    check("w_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
    tick();
    check("w_inst1", inst2, mem(32'hFFFF_FFFC));
    check("w_pc4", ipc42, 32'h0000_0000);
    check("w_addr2", bus2.imem_addr, 32'h0000_0000);
    tick();
    check("w_inst2", inst2, mem(32'h0));
    check("w_valid", {31'd0, valid2}, 32'd1);
    rst2 = 1'b1;
    tick();
    check("w_rst_addr", bus2.imem_addr, 32'hFFFF_FFF8);
    check("w_rst_valid", {31'd0, valid2}, 32'd0);
    check("w_rst_req", {31'd0, bus2.imem_req}, 32'd0);
    check("w_rst_inst", inst2, NOP);

    // reset of the first instance while stalled in hold
    stall = 1'b1;
    tick();
    check("pre_rst_state", {30'd0, st}, 32'd2);
    rst = 1'b1;
    tick();
    check("mid_rst_state", {30'd0, st}, 32'd0);
    check("mid_rst_addr", bus.imem_addr, 32'd0);
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_perf", pf, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
